// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, then shifts one command byte out on device clocks.
// Optional watchdog for a silent device is enabled with `define PS2TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        PS2C,
    inout  wire        PS2D,
    input  logic       wrn,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);

    state_t        r_state;
    logic [IW-1:0] r_cnt;
    logic [3:0]    r_bitcnt;
    logic [9:0]    r_shift;
    logic          r_drv_c;
    logic          r_drv_d;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_ack_ok;
    logic [1:0]    r_c_sync;
    logic [1:0]    r_d_sync;
    logic          r_c_prev;
    logic          w_c;
    logic          w_d;
    logic          w_fall;

    // Open-drain: a set enable pulls the line low, otherwise it is released.
    assign PS2C = r_drv_c ? 1'b0 : 1'bz;
    assign PS2D = r_drv_d ? 1'b0 : 1'bz;

    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

    assign w_c    = r_c_sync[1];
    assign w_d    = r_d_sync[1];
    assign w_fall = r_c_prev & ~w_c;

    // NOTE: synchronisers reset to 1 (idle bus level) so no false edge appears as reset releases.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_c_sync <= 2'b11;
            r_d_sync <= 2'b11;
            r_c_prev <= 1'b1;
        end else begin
            r_c_sync <= {r_c_sync[0], PS2C};
            r_d_sync <= {r_d_sync[0], PS2D};
            r_c_prev <= w_c;
        end
    end

`ifdef PS2TX_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] r_wdog;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // NOTE: all state here uses non-blocking assignments; later assignments in the block
    // (the watchdog) deliberately override the case statement within the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_shift  <= '1;
            r_drv_c  <= 1'b0;
            r_drv_d  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ack_ok <= 1'b0;
`ifdef PS2TX_TIMEOUT_EN
            r_wdog   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_drv_c <= 1'b0;
                    r_drv_d <= 1'b0;
                    if (!wrn) begin
                        r_shift <= {1'b1, ~^din, din};
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_drv_c <= 1'b1;
                        r_state <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    r_cnt <= r_cnt + IW'(1);
                    if (r_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                        r_drv_d <= 1'b1;
                        r_state <= S_RTS;
                    end
                end
                S_RTS: begin
                    r_drv_c  <= 1'b0;
                    r_bitcnt <= '0;
                    r_state  <= S_SEND;
`ifdef PS2TX_TIMEOUT_EN
                    r_wdog   <= '0;
`endif
                end
                S_SEND: begin
                    // Data changes only on device falling edges; the start bit is already on the line.
                    if (w_fall) begin
                        r_drv_d  <= ~r_shift[0];
                        r_shift  <= {1'b1, r_shift[9:1]};
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd9) begin
                            r_state <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    r_drv_d <= 1'b0;
                    if (w_fall) begin
                        r_ack_ok <= ~w_d;
                        r_state  <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (w_c && w_d) begin
                        r_done  <= 1'b1;
                        r_err   <= ~r_ack_ok;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_drv_c <= 1'b0;
                    r_drv_d <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
`ifdef PS2TX_TIMEOUT_EN
            if (r_state == S_SEND || r_state == S_ACK || r_state == S_WAIT_IDLE) begin
                r_wdog <= w_fall ? '0 : r_wdog + WW'(1);
                if (r_wdog == WW'(TIMEOUT_CYCLES - 1)) begin
                    r_drv_c <= 1'b0;
                    r_drv_d <= 1'b0;
                    r_done  <= 1'b1;
                    r_err   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host and
// compares the bits it samples with a frame built from the byte, odd parity and stop rules.
module tb_ps2_host_tx;

    localparam int INHIBIT = 50;
    localparam int TIMEOUT = 2000;
    localparam int HALF    = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wrn = 1'b1;
    logic [7:0] din = 8'h00;
    logic       busy;
    logic       done;
    logic       err;
    wire        ps2c;
    wire        ps2d;
    logic       dev_c = 1'b0;
    logic       dev_d = 1'b0;

    int checks   = 0;
    int failures = 0;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c ? 1'b0 : 1'bz;
    assign ps2d = dev_d ? 1'b0 : 1'bz;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .PS2C(ps2c),
        .PS2D(ps2d),
        .wrn (wrn),
        .din (din),
        .busy(busy),
        .done(done),
        .err (err)
    );

    always #5 clk = ~clk;

    // Records every done pulse, the err/busy seen with it, and any pulse longer than a cycle.
    int   done_count = 0;
    logic done_err   = 1'b0;
    logic done_busy  = 1'b0;
    bit   long_pulse = 1'b0;
    bit   prev_done  = 1'b0;
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count = done_count + 1;
            done_err   = err;
            done_busy  = busy;
            if (prev_done) long_pulse = 1'b1;
        end
        prev_done = (done === 1'b1);
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "global timeout");
    end

    function automatic logic [9:0] expected_frame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b};
    endfunction

    task automatic start_tx(input logic [7:0] b);
        @(negedge clk);
        din = b;
        wrn = 1'b0;
        @(negedge clk);
        wrn = 1'b1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_rts(output int low_n, output logic d_last, output bit ok);
        int n;
        ok     = 1'b0;
        low_n  = 0;
        d_last = 1'b1;
        n      = 0;
        while (ps2c !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (ps2c !== 1'b0) return;
        while (ps2c === 1'b0 && low_n < 2000) begin
            d_last = ps2d;
            low_n++;
            @(negedge clk);
        end
        ok = (ps2c === 1'b1);
    endtask

    // Device side of one frame: 11 clock pulses, data sampled just before each rising edge.
    task automatic run_device(input bit ack, input int wr_edge, input int rst_edge,
                              output logic [9:0] sampled);
        sampled = '0;
        repeat (50) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && ack) begin
                dev_d = 1'b1;
                repeat (20) @(negedge clk);
            end
            dev_c = 1'b1;
            repeat (HALF) @(negedge clk);
            if (k <= 10) sampled[k-1] = ps2d;
            dev_c = 1'b0;
            if (k == wr_edge) begin
                din = 8'h55;
                wrn = 1'b0;
                @(negedge clk);
                wrn = 1'b1;
            end
            if (k == rst_edge) begin
                #2 rst = 1'b0;
                #1;
                checks++;
                if ({ps2c, ps2d, busy, done, err} !== 5'b11000) begin
                    failures++;
                    $display("FAIL mid_frame_reset: {ps2c,ps2d,busy,done,err}=%b required 11000",
                             {ps2c, ps2d, busy, done, err});
                end
                repeat (3) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                return;
            end
            repeat (HALF) @(negedge clk);
        end
        dev_d = 1'b0;
    endtask

    task automatic do_frame(input string name, input logic [7:0] b, input bit ack,
                            input int wr_edge, input int rst_edge);
        int         dc0;
        int         low_n;
        int         n;
        logic       d_last;
        bit         ok;
        logic [9:0] sampled;
        dc0        = done_count;
        long_pulse = 1'b0;
        start_tx(b);
        din = 8'($urandom);
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL %s accept: busy=%b err=%b required busy=1 err=0", name, busy, err);
        end
        wait_rts(low_n, d_last, ok);
        checks++;
        if (!ok || low_n < INHIBIT || d_last !== 1'b0) begin
            failures++;
            $display("FAIL %s rts: ok=%0d clk_low=%0d data_before_release=%b required ok=1 low>=%0d data=0",
                     name, ok, low_n, d_last, INHIBIT);
        end
        if (!ok) return;
        run_device(ack, wr_edge, rst_edge, sampled);
        if (rst_edge > 0) return;
        n = 0;
        while (done_count == dc0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (sampled !== expected_frame(b)) begin
            failures++;
            $display("FAIL %s bits: device sampled %b required %b", name, sampled, expected_frame(b));
        end
        checks++;
        if (done_count !== dc0 + 1 || long_pulse) begin
            failures++;
            $display("FAIL %s done: pulses=%0d long=%0d required pulses=1 long=0",
                     name, done_count - dc0, long_pulse);
        end
        checks++;
        if (done_err !== ~ack || done_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s status: err=%b busy=%b at done, required err=%b busy=0",
                     name, done_err, done_busy, ~ack);
        end
        checks++;
        if (busy !== 1'b0 || err !== ~ack || ps2c !== 1'b1 || ps2d !== 1'b1) begin
            failures++;
            $display("FAIL %s idle: busy=%b err=%b ps2c=%b ps2d=%b required 0 %b 1 1",
                     name, busy, err, ps2c, ps2d, ~ack);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #7;
        checks++;
        if ({ps2c, ps2d, busy, done, err} !== 5'b11000) begin
            failures++;
            $display("FAIL reset: {ps2c,ps2d,busy,done,err}=%b required 11000",
                     {ps2c, ps2d, busy, done, err});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        do_frame("set_leds_ed", 8'hED, 1'b1, 0, 0);
        do_frame("single_bit_01", 8'h01, 1'b1, 0, 0);
    endtask

    task automatic test_no_ack();
        do_frame("no_ack_f4", 8'hF4, 1'b0, 0, 0);
        repeat (100) @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL no_ack_hold: err=%b busy=%b required err=1 busy=0", err, busy);
        end
        do_frame("after_no_ack", 8'($urandom), 1'b1, 0, 0);
    endtask

    task automatic test_timeout();
        int   dc0;
        int   low_n;
        int   n;
        logic d_last;
        bit   ok;
        dc0 = done_count;
        start_tx(8'hFF);
        wait_rts(low_n, d_last, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL timeout_rts: request-to-send not seen (low=%0d)", low_n);
        end
`ifdef PS2TX_TIMEOUT_EN
        n = 0;
        while (done_count == dc0 && n < TIMEOUT + 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_count !== dc0 + 1 || n < TIMEOUT - 10 || n > TIMEOUT + 10 || done_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout: pulses=%0d after=%0d err=%b required 1 pulse ~%0d cycles err=1",
                     done_count - dc0, n, done_err, TIMEOUT);
        end
        @(negedge clk);
        checks++;
        if (ps2c !== 1'b1 || ps2d !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_release: ps2c=%b ps2d=%b busy=%b required 1 1 0", ps2c, ps2d, busy);
        end
`else
        n = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        checks++;
        if (n != 10000 || done_count !== dc0) begin
            failures++;
            $display("FAIL silent_device: busy for %0d of 10000 cycles, pulses=%0d required 10000 and 0",
                     n, done_count - dc0);
        end
        apply_reset();
        checks++;
        if (ps2c !== 1'b1 || ps2d !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL silent_recover: ps2c=%b ps2d=%b busy=%b required 1 1 0", ps2c, ps2d, busy);
        end
`endif
    endtask

    task automatic test_wrn_ignored();
        do_frame("wrn_in_send", 8'hA3, 1'b1, 3, 0);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'($urandom) & 8'hF7;
        do_frame("mid_reset", b, 1'b1, 0, 4);
        do_frame("after_reset", 8'($urandom), 1'b1, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) begin
            do_frame("random", 8'($urandom), 1'b1, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_ack();
        test_timeout();
        test_wrn_ignored();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
